pc_gen: RTL
===========

Name: pc_gen

Overview:
- Next-generation fetch-address unit: owns the architectural PC register rather than only computing a combinational next PC.
- Prioritised redirects: exception vector, ERET, and ID-stage jump/branch/register.
- Holds a redirect that arrives while fetch is stalled and applies it on release.
- Exception vectors are parametrised as base + code × stride. An optional return-address stack predicts `jr $31` targets.
- Sits between the IF stage and the IF/ID register; replaces the standalone next-PC logic.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset
- EXC_W, 4, width of exception code
- VEC_BASE, 32'h0000_4180, vector for exception code 0
- VEC_STRIDE, 32'h20, byte spacing between consecutive vectors
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2); used only with PC_GEN_RAS_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold PC (IF stall)
- exc_valid  in  1  take exception this cycle
- exc_code  in  EXC_W  exception index
- eret_valid  in  1  return from exception
- cp0_epc  in  32  ERET target
- br_op  in  2  00 none, 01 JUMP, 10 OFFSET, 11 RS
- pc_id  in  32  PC of instruction in ID
- imm16  in  16  branch offset
- imm26  in  26  jump index
- rs_data  in  32  forwarded rs value
- call_id  in  1  ID holds JAL/JALR
- ret_id  in  1  ID holds `jr $31`
- rs_ready  in  1  rs_data forwarding is valid
- pc  out  32  current fetch PC
- re_addr  out  32  pc_id+8 (link value)
- pend_valid  out  1  redirect held pending
- ras_used  out  1  RS target came from RAS this cycle

Behaviour:
- **Reset** (rst_n=0 at posedge):
  - pc=RESET_PC, pend_valid=0, pending class/target cleared.
  - RAS pointer=0, RAS count=0, ras_used=0.
  - Reset mid-stall discards any pending redirect.
- **Redirect classes and targets**, in priority EXC(3) > ERET(2) > BR(1) > NONE(0):
  - EXC target = VEC_BASE + exc_code×VEC_STRIDE. Compute modulo 2^32 and zero-extend exc_code.
  - ERET target = cp0_epc.
  - BR JUMP target = {pc_id[31:28], imm26, 2'b00}.
  - BR OFFSET target = pc_id + 4 + sign_ext(imm16)<<2, modulo 2^32.
  - BR RS target = rs_data; see the optional feature for the RAS case.
- **Effective request**: the higher of the incoming class and the pending class. On a tie, the incoming request wins (newer data).
- **stall=0**: pc ← effective target, or pc+4 if the class is NONE. pend_valid ← 0. Latency is one cycle from request to pc.
- **stall=1**: pc holds. If effective class is not NONE: pending ← effective request, pend_valid ← 1. A lower class never overwrites a higher pending class.
- **re_addr**: combinational pc_id + 8.
- **pc+4**: wraps modulo 2^32, with no error.
- **No handshake back**: requesters pulse for one cycle; pc_gen guarantees the request is not lost across any stall length.

Optional Feature:
- **Macro**: PC_GEN_RAS_EN.
- **With the macro defined**: circular RAS of RAS_DEPTH×32.
  - call_id=1 (not stalled) pushes re_addr.
  - ret_id=1 with br_op=RS and rs_ready=0 and count>0: target = top entry, pop, ras_used=1.
  - rs_ready=1 always uses rs_data. It still pops if count>0, with ras_used=0.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no pop, target = rs_data, ras_used=0.
  - Push and pop in the same cycle: pop, then push.
  - RAS is frozen while stall=1.
  - Misprediction is corrected by a later BR redirect from the checker.
- **Without the macro**: no RAS storage. ras_used is tied to 0. ret_id and rs_ready are ignored.

Decomposition:
- **Shared package**: br_op encodings, redirect class constants (NONE/BR/ERET/EXC), reset PC and vector defaults.
- **Sub-module**: pc_gen_ras (circular stack, pointer/count logic), instantiated only under PC_GEN_RAS_EN.

Test Plan:
- **Reset, then free run**: release rst_n, stall=0 → pc=3000, 3004, 3008 on successive cycles.
- **JUMP**: br_op=01, pc_id=0x0040_0010, imm26=0x0000100 → next pc=0x0000_0400.
- **OFFSET backward**: pc_id=0x3010, imm16=0xFFFE → pc=0x300C.
- **Stall collision**: stall=1 for 3 cycles. BR to 0x3100 in cycle 1, then exc_code=2 in cycle 2 → pend_valid=1, pc held. On release, pc=0x41C0 (exception wins), pend_valid=0.
- **Same-cycle priority**: exc_valid, eret_valid and br_op all asserted with stall=0 → pc=vector. ERET+BR only → pc=cp0_epc.
- **RAS (macro on, RAS_DEPTH=4)**:
  - Five calls → oldest entry overwritten.
  - Five returns with rs_ready=0 → targets are last four links in LIFO order with ras_used=1. Fifth return uses rs_data with ras_used=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address unit: branch-op encodings,
// redirect classes, default reset PC / exception-vector geometry and
// the target-computation helpers.
package pc_gen_pkg;

  // ID-stage branch operation encoding
  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_JUMP   = 2'b01,
    BR_OFFSET = 2'b10,
    BR_RS     = 2'b11
  } br_op_e;

  // Redirect classes; numeric order is the priority order
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_BR   = 2'd1,
    CLS_ERET = 2'd2,
    CLS_EXC  = 2'd3
  } redir_cls_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_4180;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0020;
  localparam int unsigned DEF_RAS_DEPTH  = 4;

  // J-type target: region bits of the ID PC, word index, byte alignment
  function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                              input logic [25:0] imm26);
    return {pc_hi, imm26, 2'b00};
  endfunction

  // Branch target: delay-slot PC plus sign-extended word offset, mod 2^32
  function automatic logic [31:0] offset_target(input logic [31:0] pc_id,
                                                input logic [15:0] imm16);
    return pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack. Push at the free slot, pop from the
// slot below it; a push into a full stack overwrites the oldest entry
// and the count saturates. Pop then push within one cycle.
// Used only when the PC_GEN_RAS_EN macro is defined.
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [31:0] i_push_data,
  output logic [31:0] o_top,
  output logic        o_nonempty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_do_pop;
  logic [PTR_W-1:0] w_ptr_top;
  logic [PTR_W-1:0] w_ptr_after_pop;

  assign w_do_pop        = i_pop && (r_cnt != '0);
  assign w_ptr_top       = r_ptr - PTR_W'(1);
  assign w_ptr_after_pop = w_do_pop ? w_ptr_top : r_ptr;
  assign o_top           = r_mem[w_ptr_top];
  assign o_nonempty      = (r_cnt != '0);

  // Stack storage, pointer and occupancy update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      // pop-then-push: write lands in the slot just vacated by the pop
      r_mem[w_ptr_after_pop] <= i_push_data;
      r_ptr                  <= w_ptr_after_pop + PTR_W'(1);
      if (!w_do_pop && (r_cnt != CNT_W'(RAS_DEPTH))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (w_do_pop) begin
      r_ptr <= w_ptr_top;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address unit: owns the architectural PC, arbitrates redirects
// (EXC > ERET > BR > sequential) and keeps any redirect seen during an
// IF stall pending until the stall releases.
// Optional return-address stack for `jr $31`: define PC_GEN_RAS_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned EXC_W      = 4,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int unsigned RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exc_valid,
  input  logic [EXC_W-1:0] exc_code,
  input  logic             eret_valid,
  input  logic [31:0]      cp0_epc,
  input  logic [1:0]       br_op,
  input  logic [31:0]      pc_id,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [31:0]      rs_data,
  input  logic             call_id,
  input  logic             ret_id,
  input  logic             rs_ready,
  output logic [31:0]      pc,
  output logic [31:0]      re_addr,
  output logic             pend_valid,
  output logic             ras_used
);

  logic [31:0] r_pc;
  logic        r_pend_valid;
  redir_cls_e  r_pend_cls;
  logic [31:0] r_pend_tgt;

  logic [31:0] w_code_ext;
  logic [31:0] w_exc_tgt;
  logic [31:0] w_rs_tgt;
  logic [31:0] w_br_tgt;
  redir_cls_e  w_in_cls;
  logic [31:0] w_in_tgt;
  redir_cls_e  w_eff_cls;
  logic [31:0] w_eff_tgt;

  assign re_addr    = pc_id + 32'd8;
  assign w_code_ext = {{(32-EXC_W){1'b0}}, exc_code};
  assign w_exc_tgt  = VEC_BASE + w_code_ext * VEC_STRIDE;

`ifdef PC_GEN_RAS_EN
  logic        w_ras_ret;
  logic        w_ras_hit;
  logic [31:0] w_ras_top;
  logic        w_ras_nonempty;

  assign w_ras_ret = ret_id && (br_op_e'(br_op) == BR_RS);
  assign w_ras_hit = w_ras_ret && !rs_ready && w_ras_nonempty;
  assign w_rs_tgt  = w_ras_hit ? w_ras_top : rs_data;
  assign ras_used  = w_ras_hit;

  // stack is frozen while fetch is stalled
  pc_gen_ras #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (call_id && !stall),
    .i_pop       (w_ras_ret && !stall),
    .i_push_data (re_addr),
    .o_top       (w_ras_top),
    .o_nonempty  (w_ras_nonempty)
  );
`else
  logic w_unused_ras;

  assign w_unused_ras = ^{call_id, ret_id, rs_ready};
  assign w_rs_tgt     = rs_data;
  assign ras_used     = 1'b0;
`endif

  // Incoming request: class and target of the highest-priority source
  always_comb begin
    w_br_tgt = '0;
    case (br_op_e'(br_op))
      BR_JUMP:   w_br_tgt = jump_target(pc_id[31:28], imm26);
      BR_OFFSET: w_br_tgt = offset_target(pc_id, imm16);
      BR_RS:     w_br_tgt = w_rs_tgt;
      default:   w_br_tgt = '0;
    endcase

    w_in_cls = CLS_NONE;
    w_in_tgt = '0;
    if (exc_valid) begin
      w_in_cls = CLS_EXC;
      w_in_tgt = w_exc_tgt;
    end else if (eret_valid) begin
      w_in_cls = CLS_ERET;
      w_in_tgt = cp0_epc;
    end else if (br_op_e'(br_op) != BR_NONE) begin
      w_in_cls = CLS_BR;
      w_in_tgt = w_br_tgt;
    end
  end

  // Effective request: higher of incoming and pending, incoming on a tie
  always_comb begin
    w_eff_cls = w_in_cls;
    w_eff_tgt = w_in_tgt;
    if (w_in_cls < r_pend_cls) begin
      w_eff_cls = r_pend_cls;
      w_eff_tgt = r_pend_tgt;
    end
  end

  // PC register and pending-redirect holding across stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_cls   <= CLS_NONE;
      r_pend_tgt   <= '0;
    end else if (!stall) begin
      r_pc         <= (w_eff_cls == CLS_NONE) ? r_pc + 32'd4 : w_eff_tgt;
      r_pend_valid <= 1'b0;
      r_pend_cls   <= CLS_NONE;
      r_pend_tgt   <= '0;
    end else if (w_eff_cls != CLS_NONE) begin
      r_pend_valid <= 1'b1;
      r_pend_cls   <= w_eff_cls;
      r_pend_tgt   <= w_eff_tgt;
    end
  end

  assign pc         = r_pc;
  assign pend_valid = r_pend_valid;

endmodule
